pifo_dequeue_scheduler: RTL
===========================

// Module: pifo_dequeue_scheduler
// PURPOSE
// Sequences dequeues from pifo_queue_manager on behalf of idle cores. Queues core credit requests,
// pops the highest-priority app handle from the PIFO, issues the one-cycle descriptor request to
// the queue manager, and forwards the descriptor with its core id to the core dispatch path.
// Sits between the PIFO, pifo_queue_manager (m_packet_desc_* side) and the per-core TX-to-host logic.
// PARAMETERS
// CORE_ID_WIDTH    4   width of core identifier
// CORE_FIFO_DEPTH  16  pending core-request entries (power of 2)
// POP_TIMEOUT      15  cycles to wait for pifo_pop_valid before abandoning the pop
// STAT_WIDTH       32  width of statistics counters
// PORTS
// clk                   in   1                      clock
// rst_n                 in   1                      reset, synchronous, active-low
// s_core_req_valid      in   1                      core is idle and requests one descriptor
// s_core_req_core_id    in   CORE_ID_WIDTH          requesting core
// s_core_req_ready      out  1                      core FIFO not full
// pifo_empty            in   1                      PIFO holds no app handles
// pifo_pop_req          out  1                      pop the min-rank handle (one-cycle pulse)
// pifo_pop_valid        in   1                      popped handle is valid
// pifo_pop_data         in   `RL_DESC_APP_ID_SIZE   popped app id
// m_packet_desc_req     out  1                      dequeue strobe to queue manager (one-cycle pulse)
// m_packet_desc_app_id  out  `RL_DESC_APP_ID_SIZE   queue to dequeue
// m_packet_desc         in   `RL_DESC_WIDTH         descriptor, same cycle as req
// m_packet_desc_valid   in   1                      descriptor valid, same cycle as req
// m_pifo_empty          in   1                      addressed queue was empty, same cycle as req
// m_sched_desc_valid    out  1                      dispatch output valid
// m_sched_desc          out  `RL_DESC_WIDTH         dispatched descriptor
// m_sched_core_id       out  CORE_ID_WIDTH          destination core
// m_sched_app_id        out  `RL_DESC_APP_ID_SIZE   owning app
// m_sched_desc_ready    in   1                      dispatch output accepted
// stat_dispatch_cnt     out  STAT_WIDTH             descriptors dispatched
// stat_miss_cnt         out  STAT_WIDTH             pops that hit an empty queue or timed out
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): FSM=IDLE; core FIFO flushed; all *_req/*_valid outputs 0; data outputs 0;
//   stats 0; timeout counter 0. Reset mid-operation abandons any popped handle/descriptor (no replay).
// - Core FIFO: accept on s_core_req_valid && s_core_req_ready; ready=0 when CORE_FIFO_DEPTH entries held.
//   Head entry is consumed only on dispatch handshake, never on a miss (core keeps its place).
// - FSM states: IDLE, POP, WAIT_POP, DEQ, SEND.
//   IDLE:     core FIFO non-empty && !pifo_empty -> POP.
//   POP:      pifo_pop_req=1 for exactly one cycle; clear timeout counter -> WAIT_POP.
//   WAIT_POP: pifo_pop_valid -> latch pifo_pop_data to app_reg -> DEQ. Counter hits POP_TIMEOUT ->
//             stat_miss_cnt++ -> IDLE. pifo_pop_valid in the same cycle as timeout wins (-> DEQ).
//   DEQ:      m_packet_desc_req=1, m_packet_desc_app_id=app_reg, exactly one cycle. Sample same cycle:
//             m_packet_desc_valid=1 -> latch desc, core id (FIFO head), app -> SEND;
//             else (m_pifo_empty=1 or no valid) -> stat_miss_cnt++ -> IDLE.
//   SEND:     m_sched_desc_valid=1, outputs stable until m_sched_desc_ready; on handshake pop core FIFO,
//             stat_dispatch_cnt++ -> IDLE.
// - Latency: core req with PIFO ready and pop_valid one cycle after pop -> m_sched_desc_valid 4 cycles later.
// - At most one outstanding pop/dequeue; m_packet_desc_req never asserted outside DEQ.
// - Counters saturate at all-ones (no wrap). Core FIFO pointers wrap modulo CORE_FIFO_DEPTH.
// - Simultaneous FIFO push and pop (SEND handshake) in one cycle: both take effect, occupancy unchanged;
//   push on full FIFO with a same-cycle pop is still refused (ready computed from registered occupancy).
// - Re-enqueue of the app handle into the PIFO is done by the queue manager; this block never pushes.
// STRUCTURE
// - Widths (`RL_DESC_WIDTH, `RL_DESC_APP_ID_SIZE) come from define.v; add `RL_CORE_ID_SIZE there.
// - FSM state encodings as localparams in this file.
// - Core request FIFO: instantiate axis_fifo (DATA_WIDTH=CORE_ID_WIDTH, DEPTH=CORE_FIFO_DEPTH,
//   all optional sidebands disabled); no other sub-module.
// TESTING
// 1 Reset: hold rst_n=0 3 cycles mid-SEND -> all valids/reqs 0, stats 0, s_core_req_ready=1 next cycle.
// 2 Basic: core 3 requests, PIFO pops app 2, qm returns desc 0xABCD valid -> m_sched_desc=0xABCD,
//   core_id=3, app_id=2, one pifo_pop_req and one m_packet_desc_req pulse, stat_dispatch_cnt=1.
// 3 Empty queue: pop app 1, qm m_pifo_empty=1 -> no dispatch, stat_miss_cnt=1, core 3 stays at head,
//   next pop app 0 valid -> dispatched to core 3.
// 4 Timeout: pifo_pop_valid held 0 -> return to IDLE after 15 cycles, stat_miss_cnt++, retry pop.
// 5 Backpressure/full: m_sched_desc_ready=0 for 20 cycles, 17 core requests -> outputs stable,
//   s_core_req_ready=0 after 16 accepted; release -> 16 dispatches in FIFO order.
// 6 PIFO empty: pifo_empty=1 with pending cores -> no pifo_pop_req ever asserted until it drops.

Source files
------------

// File: rtl/pifo_dequeue_scheduler_pkg.sv
// rtl/pifo_dequeue_scheduler_pkg.sv - shared widths and FSM state type for the PIFO dequeue scheduler
package pifo_dequeue_scheduler_pkg;

    localparam int RL_DESC_WIDTH       = 32;
    localparam int RL_DESC_APP_ID_SIZE = 8;
    localparam int RL_CORE_ID_SIZE     = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POP      = 3'd1,
        ST_WAIT_POP = 3'd2,
        ST_DEQ      = 3'd3,
        ST_SEND     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/pifo_dequeue_scheduler_core_fifo.sv
// rtl/pifo_dequeue_scheduler_core_fifo.sv - pending core-request FIFO, stream in/out, head shown combinationally
module pifo_dequeue_scheduler_core_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_push;
    logic                  w_pop;

    // Ready comes from registered occupancy, so a full FIFO refuses a push even when popped the same cycle.
    assign s_tready = (r_count != (AW+1)'(DEPTH));
    assign m_tvalid = (r_count != '0);
    assign m_tdata  = r_mem[r_rd_ptr];
    assign w_push   = s_tvalid && s_tready;
    assign w_pop    = m_tready && m_tvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_tdata;
        end
    end

endmodule

// File: rtl/pifo_dequeue_scheduler.sv
// rtl/pifo_dequeue_scheduler.sv - pops PIFO app handles, dequeues descriptors and dispatches them to idle cores
module pifo_dequeue_scheduler
    import pifo_dequeue_scheduler_pkg::*;
#(
    parameter int CORE_ID_WIDTH   = RL_CORE_ID_SIZE,
    parameter int CORE_FIFO_DEPTH = 16,
    parameter int POP_TIMEOUT     = 15,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_core_req_valid,
    input  logic [CORE_ID_WIDTH-1:0]       s_core_req_core_id,
    output logic                           s_core_req_ready,
    input  logic                           pifo_empty,
    output logic                           pifo_pop_req,
    input  logic                           pifo_pop_valid,
    input  logic [RL_DESC_APP_ID_SIZE-1:0] pifo_pop_data,
    output logic                           m_packet_desc_req,
    output logic [RL_DESC_APP_ID_SIZE-1:0] m_packet_desc_app_id,
    input  logic [RL_DESC_WIDTH-1:0]       m_packet_desc,
    input  logic                           m_packet_desc_valid,
    input  logic                           m_pifo_empty,
    output logic                           m_sched_desc_valid,
    output logic [RL_DESC_WIDTH-1:0]       m_sched_desc,
    output logic [CORE_ID_WIDTH-1:0]       m_sched_core_id,
    output logic [RL_DESC_APP_ID_SIZE-1:0] m_sched_app_id,
    input  logic                           m_sched_desc_ready,
    output logic [STAT_WIDTH-1:0]          stat_dispatch_cnt,
    output logic [STAT_WIDTH-1:0]          stat_miss_cnt
);

    localparam int TW = $clog2(POP_TIMEOUT + 1);

    sched_state_t                   r_state;
    sched_state_t                   w_state_nxt;
    logic [TW-1:0]                  r_timeout;
    logic [RL_DESC_APP_ID_SIZE-1:0] r_app;
    logic [RL_DESC_WIDTH-1:0]       r_desc;
    logic [CORE_ID_WIDTH-1:0]       r_sched_core;
    logic [RL_DESC_APP_ID_SIZE-1:0] r_sched_app;
    logic [STAT_WIDTH-1:0]          r_dispatch_cnt;
    logic [STAT_WIDTH-1:0]          r_miss_cnt;
    logic                           w_fifo_valid;
    logic [CORE_ID_WIDTH-1:0]       w_fifo_core;
    logic                           w_timeout;
    logic                           w_deq_hit;
    logic                           w_miss;
    logic                           w_dispatch;

    pifo_dequeue_scheduler_core_fifo #(
        .DATA_WIDTH (CORE_ID_WIDTH),
        .DEPTH      (CORE_FIFO_DEPTH)
    ) u_core_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_core_req_core_id),
        .s_tvalid (s_core_req_valid),
        .s_tready (s_core_req_ready),
        .m_tdata  (w_fifo_core),
        .m_tvalid (w_fifo_valid),
        .m_tready (w_dispatch)
    );

    // The timeout fires on the POP_TIMEOUT-th cycle spent in WAIT_POP; a pop_valid that same cycle still wins.
    assign w_timeout = (r_timeout == TW'(POP_TIMEOUT - 1));
    assign w_deq_hit = m_packet_desc_valid && !m_pifo_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_miss      = 1'b0;
        w_dispatch  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fifo_valid && !pifo_empty) begin
                    w_state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                w_state_nxt = ST_WAIT_POP;
            end
            ST_WAIT_POP: begin
                if (pifo_pop_valid) begin
                    w_state_nxt = ST_DEQ;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_miss      = 1'b1;
                end
            end
            ST_DEQ: begin
                if (w_deq_hit) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_miss      = 1'b1;
                end
            end
            ST_SEND: begin
                if (m_sched_desc_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_dispatch  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout      <= '0;
            r_app          <= '0;
            r_desc         <= '0;
            r_sched_core   <= '0;
            r_sched_app    <= '0;
            r_dispatch_cnt <= '0;
            r_miss_cnt     <= '0;
        end else begin
            if (r_state == ST_POP) begin
                r_timeout <= '0;
            end else if (r_state == ST_WAIT_POP) begin
                r_timeout <= r_timeout + 1'b1;
            end
            if (r_state == ST_WAIT_POP && pifo_pop_valid) begin
                r_app <= pifo_pop_data;
            end
            if (r_state == ST_DEQ && w_deq_hit) begin
                r_desc       <= m_packet_desc;
                r_sched_core <= w_fifo_core;
                r_sched_app  <= r_app;
            end
            if (w_miss && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (w_dispatch && !(&r_dispatch_cnt)) begin
                r_dispatch_cnt <= r_dispatch_cnt + 1'b1;
            end
        end
    end

    assign pifo_pop_req         = (r_state == ST_POP);
    assign m_packet_desc_req    = (r_state == ST_DEQ);
    assign m_packet_desc_app_id = r_app;
    assign m_sched_desc_valid   = (r_state == ST_SEND);
    assign m_sched_desc         = r_desc;
    assign m_sched_core_id      = r_sched_core;
    assign m_sched_app_id       = r_sched_app;
    assign stat_dispatch_cnt    = r_dispatch_cnt;
    assign stat_miss_cnt        = r_miss_cnt;

endmodule
